// File: rtl/layer3_pool_pack_if.sv
// Pixel-in / pooled-word-out handshake bundle for layer3_pool_pack.
interface layer3_pool_pack_if #(
  parameter int unsigned CH = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [CH-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CH-1:0] out_data;
  logic          out_last;

  // Pooling block view
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer view
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/layer3_pool_pack.sv
// 2x2 / stride-2 binary max pooling (bitwise OR) of the layer-3 activation map.
// Row pairs are combined through a half-width line buffer; one pooled word per window.
module layer3_pool_pack #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned CH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  layer3_pool_pack_if.slave          bus,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned LbN  = IMG_W / 2;
  localparam int unsigned LbW  = (LbN > 1) ? $clog2(LbN) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [CH-1:0]   hold_q, hold_d;
  logic [CH-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            frame_done_q, frame_done_d;
  logic [CH-1:0]   linebuf_q [LbN];

  logic            accept;
  logic            last_col;
  logic            last_px;
  logic            lb_we;
  logic [LbW-1:0]  lb_idx;
  logic [CH-1:0]   lb_wdata;

  // Stall input whenever the single output slot is full and not being drained
  assign bus.in_ready  = (state_q == StRun) && !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_col = (col_q == ColW'(IMG_W - 1));
  assign last_px  = last_col && (row_q == RowW'(IMG_H - 1));
  assign lb_idx   = LbW'(col_q >> 1);
  assign lb_wdata = hold_q | bus.in_data;

  // Next-state: frame sequencing, raster counters, window accumulation, output slot
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    lb_we        = 1'b0;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
          hold_d  = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = (row_q == RowW'(IMG_H - 1)) ? '0 : row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          // {odd row, odd col} selects the role of this pixel in its window
          unique case ({row_q[0], col_q[0]})
            2'b00: hold_d = bus.in_data;
            2'b01: lb_we  = 1'b1;
            2'b10: hold_d = linebuf_q[lb_idx] | bus.in_data;
            2'b11: begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q | bus.in_data;
              out_last_d  = last_px;
            end
          endcase
          if (last_px) state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers, cleared by asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer holds even-row pair ORs; always written before read, so no reset
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= lb_wdata;
  end
endmodule

// File: tb/tb_layer3_pool_pack.sv
// Self-checking bench for layer3_pool_pack on a 4x4 map with randomized traffic.
module tb_layer3_pool_pack;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NWIN = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;

  layer3_pool_pack_if #(.CH(32)) bus ();

  layer3_pool_pack #(.IMG_W(W), .IMG_H(H), .CH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int out_cnt = 0;

  logic [31:0] pix  [NPIX];
  logic [31:0] expw [NWIN];
  logic [32:0] exp_q [$];   // {last, data}

  int ready_mode = 0;       // 0: always ready, 1: random
  bit stall_arm  = 1'b0;
  int stall_left = 0;

  bit          fd_prev    = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] data_prev  = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready: optional 5-cycle stall on first pooled word, else fixed/random
  always @(posedge clk) begin
    #1;
    if (stall_arm && bus.out_valid) begin
      stall_arm  = 1'b0;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 1) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard, stall behaviour, frame_done timing
  always @(negedge clk) begin
    if (!rst) begin
      fd_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check_eq("frame_done", {31'b0, frame_done}, {31'b0, fd_prev});
      if (fd_prev) check_eq("busy_at_done", {31'b0, busy}, 32'd0);
      if (frame_done) fd_cnt++;
      if (bus.out_valid && !bus.out_ready) check_eq("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      if (stall_prev) check_eq("stall_data", bus.out_data, data_prev);
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check_eq("out_data", bus.out_data, e[31:0]);
          check_eq("out_last", {31'b0, bus.out_last}, {31'b0, e[32]});
        end
        out_cnt++;
      end
      fd_prev = bus.out_valid && bus.out_ready && bus.out_last;
    end
  end

  // Reference: each pooled word is the OR of its 2x2 window
  task automatic build_model();
    for (int w = 0; w < NWIN; w++) expw[w] = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        expw[(r / 2) * (W / 2) + c / 2] |= pix[r * W + c];
  endtask

  task automatic load_basic();
    for (int k = 0; k < NPIX; k++) pix[k] = 32'h1 << k;
    expw[0] = 32'h0000_0033;
    expw[1] = 32'h0000_00CC;
    expw[2] = 32'h0000_3300;
    expw[3] = 32'h0000_CC00;
  endtask

  task automatic run_frame(input bit gaps, input int abort_after, input bit start_mid);
    int  i = 0;
    int  budget = 0;
    bit  acc;
    bit  aborted = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bus.in_data  = pix[0];
    bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (i < NPIX && budget < 2000 && !aborted) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      budget++;
      start = 1'b0;
      if (acc) begin
        int r = i / W;
        int c = i % W;
        if ((r % 2 == 1) && (c % 2 == 1))
          exp_q.push_back({(i == NPIX - 1), expw[(r / 2) * (W / 2) + c / 2]});
        i++;
        if (start_mid && i == 5) start = 1'b1;
        if (abort_after != 0 && i == abort_after) aborted = 1'b1;
      end
      if (aborted) begin
        bus.in_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();
      end else begin
        bus.in_data  = pix[i % NPIX];
        bus.in_valid = (i < NPIX) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
    end
    bus.in_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check_eq("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("abort_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check_eq("abort_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;
    end else begin
      check_eq("pixels_accepted", 32'(i), 32'(NPIX));
    end
  endtask

  task automatic do_frame(input string name, input bit gaps, input bit start_mid);
    int fd0 = fd_cnt;
    int oc0 = out_cnt;
    int waited = 0;
    run_frame(gaps, 0, start_mid);
    while (fd_cnt == fd0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, "_frame_done_cnt"}, 32'(fd_cnt - fd0), 32'd1);
    check_eq({name, "_out_cnt"}, 32'(out_cnt - oc0), 32'(NWIN));
    check_eq({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    check_eq({name, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset defaults with start and in_valid held high
    rst = 1'b0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    check_eq("idle_frame_done", {31'b0, frame_done}, 32'd0);
    check_eq("idle_out_data", bus.out_data, 32'd0);
    @(posedge clk); #1 bus.in_valid = 1'b0;

    // Basic pooling against fixed expected words
    load_basic();
    do_frame("basic", 1'b0, 1'b0);

    // Single all-ones pixel in window 0, all other windows zero
    for (int k = 0; k < NPIX; k++) pix[k] = '0;
    pix[1] = 32'hFFFF_FFFF;
    expw[0] = 32'hFFFF_FFFF;
    expw[1] = 32'h0;
    expw[2] = 32'h0;
    expw[3] = 32'h0;
    do_frame("ones_zeros", 1'b0, 1'b0);

    // Backpressure on the first pooled word
    load_basic();
    stall_arm = 1'b1;
    do_frame("stall", 1'b0, 1'b0);

    // Abort mid-frame with reset, then a clean frame
    load_basic();
    run_frame(1'b0, 6, 1'b0);
    load_basic();
    do_frame("post_reset", 1'b0, 1'b0);

    // start pulsed while running is ignored
    load_basic();
    do_frame("start_mid", 1'b0, 1'b1);

    // Random pixels, random input gaps and random downstream ready
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NPIX; k++) pix[k] = $urandom() & $urandom();
      build_model();
      do_frame("random", 1'b1, 1'b0);
    end
    ready_mode = 0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/layer3_pool_pack.md
# layer3_pool_pack

Downstream consumer of the layer-3 binary activation array. It accepts one 32-channel binarized pixel word per handshake, in raster order, and performs 2x2 / stride-2 max pooling. In the binary domain (bit 1 = +1) this pooling is a bitwise OR. It emits one pooled 32-bit word per window to the layer-4 input buffer over a valid/ready handshake, and marks the last word of each frame.

## Interface

Parameters:
- IMG_W, 8: input feature-map width in pixels; must be even and ≥2.
- IMG_H, 8: input feature-map height in pixels; must be even and ≥2.
- CH, 32: channels per pixel word; fixed at 32 and must match the layer-3 output bus.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle pulse that arms a new frame; honoured only in IDLE.
- in_valid, input, 1: in_data holds a valid pixel word.
- in_ready, output, 1: block accepts a pixel word this cycle.
- in_data, input, CH: binarized channel vector from the layer-3 array.
- out_valid, output, 1: out_data holds a pooled word.
- out_ready, input, 1: downstream accepts out_data this cycle.
- out_data, output, CH: pooled channel vector.
- out_last, output, 1: qualifies out_data; high for the final pooled word of the frame.
- busy, output, 1: high in RUN or DRAIN.
- frame_done, output, 1: one-cycle pulse after the last pooled word is accepted.

## Operation

- States:
  - IDLE: in_ready=0. start moves to RUN and clears col, row and the hold register.
  - RUN: accepts pixels. Acceptance of pixel (row=IMG_H-1, col=IMG_W-1) moves to DRAIN.
  - DRAIN: waits for out_valid&&out_ready on the last word, then returns to IDLE and pulses frame_done.
- Counters: col runs 0..IMG_W-1 and wraps to 0, incrementing row. row runs 0..IMG_H-1. Both advance only on accept (in_valid&&in_ready).
- Storage:
  - hold: one CH-bit register.
  - linebuf: IMG_W/2 entries of CH bits, indexed by col>>1.
- Per accepted pixel:
  - Even row, even col: hold ← in_data.
  - Even row, odd col: linebuf[col>>1] ← hold | in_data.
  - Odd row, even col: hold ← linebuf[col>>1] | in_data.
  - Odd row, odd col: out_data ← hold | in_data; out_valid ← 1; out_last ← (row==IMG_H-1 && col==IMG_W-1).
- Output register is a single entry. out_valid clears on out_ready unless a new word is loaded in the same cycle.
- in_ready = (state==RUN) && !(out_valid && !out_ready). Input stalls whenever the output slot is occupied and not draining.
- Simultaneous accept-out and load-new in the same cycle is legal. The new word replaces the old one with out_valid staying 1.
- start asserted outside IDLE is ignored. in_valid in IDLE or DRAIN is not accepted.
- Reset, including mid-frame: state=IDLE, col=row=0, hold=0, out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0, in_ready=0. linebuf is not reset; it is always written before it is read within a frame.

## Timing

- Pooled word latency: out_valid rises the cycle after the bottom-right pixel of its window is accepted.
- Sustained throughput: 1 input pixel per cycle while out_ready=1. A full frame takes IMG_W*IMG_H accept cycles plus 1.
- Pooled words per frame: (IMG_W/2)*(IMG_H/2), in raster order of the pooled map.
- Pulse timing:
  - frame_done is high exactly one cycle, the cycle after the last-word handshake.
  - busy falls in the same cycle that frame_done rises.
- The earliest next start is accepted in the frame_done cycle.

## Test plan

- Reset defaults: hold rst low, drive in_valid=1 and start=1, then release rst and keep start=0 → in_ready=0, out_valid=0, busy=0, frame_done=0.
- Basic pooling, IMG_W=IMG_H=4, out_ready=1, pixel k = 32'h1<<k for k=0..15 → four words, in order:
  - 32'h0000_0033
  - 32'h0000_00CC
  - 32'h0000_3300
  - 32'h0000_CC00
  - out_last only on the fourth word; frame_done one cycle after it.
- All-ones/all-zeros mix: window with only one pixel 32'hFFFF_FFFF and the rest 0 → that window outputs 32'hFFFF_FFFF; an all-zero window outputs 32'h0.
- Backpressure: hold out_ready=0 for 5 cycles when the first pooled word appears → in_ready=0 during the stall, out_data stable, no pixel lost. After release, the output sequence equals the basic-pooling case.
- Reset mid-frame: assert rst after 6 pixels accepted, then run a full new frame → output matches the basic-pooling case with no residue from the aborted frame.
- Start during busy: pulse start in RUN → counters unaffected, still exactly four outputs, single frame_done.
